sram_line_fetcher: RTL
======================

# sram_line_fetcher

Scanline prefetch engine on the hardware side of the dual-ported SRAM multiplexer. On request, reads one line of 8-bit palette indices through the multiplexer's hardware read port (HW_ADDR / HW_READDATA) into the back half of a ping-pong line buffer. The VGA pixel path reads from the front half.

## Interface
- FB_BASE, 21'h000000: byte address of frame pixel (0,0)
- H_ACTIVE, 640: pixels per line, 1..1023
- RD_LAT, 3: cycles from HW_ADDR update to valid HW_READDATA, 2..7; must match the multiplexer pipeline
- CLK2  in  1: clock; same clock as the SRAM multiplexer
- RESET  in  1: reset, synchronous, active-high
- LINE_START  in  1: one-cycle pulse; fetch line LINE_Y
- LINE_Y  in  10: line index, sampled with LINE_START
- SWAP  in  1: one-cycle pulse; exchange front and back buffers
- PIX_X  in  10: pixel column read from the front buffer
- PIX_DATA  out  8: front-buffer byte at PIX_X, registered
- BUSY  out  1: fetch in progress
- DONE  out  1: one-cycle pulse when the last byte of a line is written
- OVERRUN  out  1: sticky; SWAP arrived while BUSY was high
- HW_ADDR  out  21: byte address to the multiplexer hardware port, registered
- HW_READDATA  in  8: data from the multiplexer hardware port

## Operation
- Reset values: HW_ADDR=0, PIX_DATA=0, BUSY=0, DONE=0, OVERRUN=0, front select=0, phase=0, all counters=0. Buffer RAM contents are not reset.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE, on LINE_START:
  - Latch line_base = FB_BASE + LINE_Y*H_ACTIVE, computed mod 2^21.
  - Latch wr_buf = ~front.
  - Clear issue and capture counters.
  - Set phase=0, BUSY=1, go to ISSUE.
- ISSUE:
  - Phase toggles every cycle.
  - On cycles with phase=0: HW_ADDR <= line_base + issue_cnt, then issue_cnt++.
  - This gives one request every 2 cycles, matching the multiplexer's hardware slot rate.
  - After issue H_ACTIVE-1 is registered, go to DRAIN. HW_ADDR holds its last value.
- Capture:
  - A valid/index tag shift register of depth RD_LAT follows each issue.
  - When the tag emerges, write HW_READDATA into buffer[wr_buf][capture_cnt], then capture_cnt++.
  - Capture runs in both ISSUE and DRAIN.
- DRAIN: when capture H_ACTIVE-1 is written, pulse DONE for one cycle, clear BUSY, go to IDLE.
- LINE_START while BUSY: ignored, with no state change.
- SWAP:
  - front <= ~front, effective from the next cycle, in any state.
  - If BUSY, also set OVERRUN. The fetch keeps writing to its latched wr_buf, which is now the front buffer.
  - OVERRUN clears only on RESET.
- LINE_START and SWAP in the same cycle from IDLE: SWAP applies first, so wr_buf = the new back buffer (the old front).
- Pixel read:
  - PIX_DATA <= buffer[front][PIX_X] on every cycle.
  - If PIX_X >= H_ACTIVE, PIX_DATA <= 0.
- RESET mid-fetch: everything returns to reset values next cycle; no DONE pulse; partial buffer contents are left as-is.

## Timing
- LINE_START at edge t: BUSY=1 and first HW_ADDR valid after edge t+1.
- Address k updates at edge t+1+2k. Its data is sampled at edge t+1+2k+RD_LAT.
- DONE is high in the cycle after edge t+2*H_ACTIVE-1+RD_LAT. BUSY is low from that same edge.
- PIX_DATA latency: 1 cycle from PIX_X.
- A SWAP at edge s affects PIX_DATA from edge s+2.
- Back-to-back lines: the next LINE_START is accepted in the cycle DONE is high.

## Structure
- Package sram_line_fetcher_pkg:
  - fetch_state_t enum {IDLE, ISSUE, DRAIN}.
  - ADDR_W=21, DATA_W=8, X_W=10.
- Sub-module line_ram: simple dual-port RAM of 2*H_ACTIVE x 8.
  - One synchronous write port.
  - One registered read port; address = {buf_sel, x}.
  - Inferrable as M9K.
- Address multiply is done once per LINE_START; it may be registered over 1 extra cycle only if all Timing numbers shift by +1, and this spec then gets updated.

## Test plan
- Reset, then idle for 10 cycles -> HW_ADDR=0, BUSY=0, DONE=0, PIX_DATA=0, OVERRUN=0.
- H_ACTIVE=8, RD_LAT=3, FB_BASE=0x100, LINE_Y=2, SRAM model returns addr[7:0] -> HW_ADDR sequence 0x110..0x117, one every 2 cycles. DONE 19 cycles after LINE_START. After SWAP, PIX_X=0..7 returns 0x10..0x17.
- LINE_Y=1023, H_ACTIVE=640, FB_BASE=0x1FFF00 -> address wraps mod 2^21. First HW_ADDR = (0x1FFF00 + 654720) & 0x1FFFFF.
- SWAP pulsed mid-fetch -> OVERRUN=1 and stays 1. Fetch still completes with DONE. Front select toggled.
- LINE_START pulsed while BUSY -> ignored. Issue sequence and DONE time unchanged.
- PIX_X=H_ACTIVE or 1023 -> PIX_DATA=0. RESET during ISSUE -> BUSY=0 next cycle, no DONE.

Source files
------------

// File: rtl/sram_line_fetcher_pkg.sv
// Shared types and widths for the scanline prefetch engine.
package sram_line_fetcher_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 8;
  localparam int X_W    = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/sram_line_fetcher_if.sv
// Hardware read port between the line fetcher (master) and the SRAM multiplexer (slave).
interface sram_line_fetcher_if;
  import sram_line_fetcher_pkg::*;

  logic [ADDR_W-1:0] HW_ADDR;
  logic [DATA_W-1:0] HW_READDATA;

  modport master (output HW_ADDR, input HW_READDATA);
  modport slave  (input HW_ADDR, output HW_READDATA);

endinterface

// File: rtl/sram_line_fetcher_line_ram.sv
// Ping-pong line buffer: 2*DEPTH bytes, one write port, one registered read port.
module sram_line_fetcher_line_ram
  import sram_line_fetcher_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic              i_wr_sel,
  input  logic [X_W-1:0]    i_wr_x,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_sel,
  input  logic [X_W-1:0]    i_rd_x,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int AW = $clog2(2 * DEPTH);

  logic [DATA_W-1:0] r_mem [2*DEPTH];
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr;

  // Half select maps to an offset of DEPTH so the array stays exactly 2*DEPTH deep.
  assign w_wr_addr = AW'(i_wr_x) + (i_wr_sel ? AW'(DEPTH) : '0);
  assign w_rd_addr = AW'(i_rd_x) + (i_rd_sel ? AW'(DEPTH) : '0);

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[w_wr_addr] <= i_wr_data;
    o_rd_data <= r_mem[w_rd_addr];
  end

endmodule

// File: rtl/sram_line_fetcher.sv
// Scanline prefetch engine: fetches one line of palette indices from SRAM into the
// back half of a ping-pong buffer while the pixel path reads the front half.
module sram_line_fetcher
  import sram_line_fetcher_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FB_BASE  = 21'h000000,
  parameter int                H_ACTIVE = 640,
  parameter int                RD_LAT   = 3
) (
  input  logic              CLK2,
  input  logic              RESET,
  input  logic              LINE_START,
  input  logic [X_W-1:0]    LINE_Y,
  input  logic              SWAP,
  input  logic [X_W-1:0]    PIX_X,
  output logic [DATA_W-1:0] PIX_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERRUN,
  sram_line_fetcher_if.master hw
);

  localparam logic [X_W-1:0]    LAST_X = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0]    H_X    = X_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] H_ADDR = ADDR_W'(H_ACTIVE);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  logic [ADDR_W-1:0] r_line_base;
  logic [ADDR_W-1:0] r_hw_addr;
  logic [X_W-1:0]    r_issue_cnt;
  logic [X_W-1:0]    r_cap_cnt;
  logic [RD_LAT-1:0] r_tag_vld;
  logic              r_phase;
  logic              r_front;
  logic              r_wr_buf;
  logic              r_busy;
  logic              r_done;
  logic              r_overrun;
  logic              r_pix_ok;

  logic              w_start;
  logic              w_issue;
  logic              w_finish;
  logic              w_capture;
  logic              w_last_cap;
  logic              w_pix_in;
  logic [X_W-1:0]    w_rd_x;
  logic [ADDR_W-1:0] w_line_base;
  logic [DATA_W-1:0] w_rd_data;

  assign w_line_base = FB_BASE + (ADDR_W'(LINE_Y) * H_ADDR);
  assign w_capture   = r_tag_vld[RD_LAT-1];
  assign w_last_cap  = w_capture && (r_cap_cnt == LAST_X);
  assign w_pix_in    = (PIX_X < H_X);
  assign w_rd_x      = w_pix_in ? PIX_X : '0;

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_issue      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (LINE_START) begin
          w_start      = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        // One request every other cycle to match the multiplexer's hardware slot.
        if (!r_phase) begin
          w_issue = 1'b1;
          if (r_issue_cnt == LAST_X) w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (w_last_cap) begin
          w_finish     = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK2) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_line_base <= '0;
      r_hw_addr   <= '0;
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
      r_tag_vld   <= '0;
      r_phase     <= 1'b0;
      r_front     <= 1'b0;
      r_wr_buf    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_pix_ok    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_done   <= w_finish;
      r_pix_ok <= w_pix_in;

      if (SWAP) begin
        r_front <= ~r_front;
        if (r_busy) r_overrun <= 1'b1;
      end

      // A simultaneous SWAP lands first, so the fetch targets the new back half.
      if (w_start) begin
        r_line_base <= w_line_base;
        r_wr_buf    <= SWAP ? r_front : ~r_front;
        r_issue_cnt <= '0;
        r_cap_cnt   <= '0;
        r_phase     <= 1'b0;
        r_busy      <= 1'b1;
      end else if (r_state == ISSUE) begin
        r_phase <= ~r_phase;
      end

      if (w_issue) begin
        r_hw_addr   <= r_line_base + ADDR_W'(r_issue_cnt);
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end

      // Read-latency tag pipe: each issue re-emerges RD_LAT cycles later.
      r_tag_vld <= {r_tag_vld[RD_LAT-2:0], w_issue};

      if (w_capture) r_cap_cnt <= r_cap_cnt + 1'b1;
      if (w_finish)  r_busy    <= 1'b0;
    end
  end

  sram_line_fetcher_line_ram #(
    .DEPTH (H_ACTIVE)
  ) u_line_ram (
    .i_clk     (CLK2),
    .i_wr_en   (w_capture),
    .i_wr_sel  (r_wr_buf),
    .i_wr_x    (r_cap_cnt),
    .i_wr_data (hw.HW_READDATA),
    .i_rd_sel  (r_front),
    .i_rd_x    (w_rd_x),
    .o_rd_data (w_rd_data)
  );

  assign PIX_DATA   = r_pix_ok ? w_rd_data : '0;
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign OVERRUN    = r_overrun;
  assign hw.HW_ADDR = r_hw_addr;

endmodule
